// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: reads operands, strobes the ALU once, writes back
// the result and owns the architectural PSW that feeds the ALU.
module alu_exec_ctrl #(
  parameter int unsigned RF_AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_instr,
  input  logic [RF_AW-1:0] dec_dst,
  input  logic [RF_AW-1:0] dec_src,
  input  logic             dec_rc,
  input  logic [15:0]      dec_const,
  input  logic             dec_psw_upd,
  output logic [RF_AW-1:0] rf_rd_addr_a,
  output logic [RF_AW-1:0] rf_rd_addr_b,
  input  logic [15:0]      rf_rd_data_a,
  input  logic [15:0]      rf_rd_data_b,
  output logic [15:0]      alu_op1,
  output logic [15:0]      alu_op2,
  output logic [5:0]       alu_instr,
  output logic             alu_instr_opt,
  output logic             alu_e,
  input  logic [15:0]      alu_result,
  input  logic [15:0]      alu_psw,
  output logic [15:0]      psw_q,
  output logic             rf_wr_en,
  output logic [RF_AW-1:0] rf_wr_addr,
  output logic [15:0]      rf_wr_data,
  output logic             illegal,
  output logic             busy
);

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 5;
  localparam int unsigned IW = 6;
  localparam logic [OW-1:0] OP_MAX = 5'h1B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LATCH,
    S_STRB,
    S_WB
  } state_t;

  state_t state_q, state_d;

  // Captured decoder fields
  logic [OW-1:0]    instr_q, instr_d;
  logic [RF_AW-1:0] dst_q, dst_d;
  logic [RF_AW-1:0] src_q, src_d;
  logic             rc_q, rc_d;
  logic [DW-1:0]    const_q, const_d;
  logic             upd_q, upd_d;

  // Next values of the registered outputs
  logic             dec_ready_d;
  logic             busy_d;
  logic [RF_AW-1:0] rd_addr_a_d, rd_addr_b_d;
  logic [DW-1:0]    op1_d, op2_d;
  logic [IW-1:0]    alu_instr_d;
  logic             alu_instr_opt_d;
  logic             alu_e_d;
  logic [DW-1:0]    psw_d;
  logic             wr_en_d;
  logic [RF_AW-1:0] wr_addr_d;
  logic [DW-1:0]    wr_data_d;
  logic             illegal_d;

  logic             can_take_c;
  logic             no_wb_c;

  // Compares and bit tests only produce flags
  assign no_wb_c = (instr_q == 5'h0A) || (instr_q == 5'h0B) ||
                   (instr_q == 5'h12) || (instr_q == 5'h13);

  // WB may hand over directly to the next instruction, giving 4-cycle throughput
  assign can_take_c = (state_q == S_IDLE) || (state_q == S_WB);

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    dst_d           = dst_q;
    src_d           = src_q;
    rc_d            = rc_q;
    const_d         = const_q;
    upd_d           = upd_q;
    rd_addr_a_d     = rf_rd_addr_a;
    rd_addr_b_d     = rf_rd_addr_b;
    op1_d           = alu_op1;
    op2_d           = alu_op2;
    alu_instr_d     = alu_instr;
    alu_instr_opt_d = alu_instr_opt;
    psw_d           = psw_q;
    wr_addr_d       = rf_wr_addr;
    wr_data_d       = rf_wr_data;
    alu_e_d         = 1'b0;
    wr_en_d         = 1'b0;
    illegal_d       = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_RD:   state_d = S_LATCH;
      S_LATCH: begin
        op1_d           = rf_rd_data_a;
        op2_d           = rc_q ? const_q : rf_rd_data_b;
        alu_instr_d     = IW'(instr_q);
        alu_instr_opt_d = upd_q;
        alu_e_d         = 1'b1;
        state_d         = S_STRB;
      end
      S_STRB: begin
        wr_data_d = alu_result;
        wr_addr_d = dst_q;
        wr_en_d   = ~no_wb_c;
        state_d   = S_WB;
      end
      S_WB: begin
        psw_d   = alu_psw;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Accept a new instruction; an illegal opcode only pulses illegal
    if (can_take_c && dec_valid) begin
      instr_d = dec_instr;
      dst_d   = dec_dst;
      src_d   = dec_src;
      rc_d    = dec_rc;
      const_d = dec_const;
      upd_d   = dec_psw_upd;
      if (dec_instr > OP_MAX) begin
        illegal_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        rd_addr_a_d = dec_dst;
        rd_addr_b_d = dec_src;
        state_d     = S_RD;
      end
    end

    dec_ready_d = (state_d == S_IDLE) || (state_d == S_WB);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      dst_q         <= '0;
      src_q         <= '0;
      rc_q          <= 1'b0;
      const_q       <= '0;
      upd_q         <= 1'b0;
      dec_ready     <= 1'b1;
      busy          <= 1'b0;
      rf_rd_addr_a  <= '0;
      rf_rd_addr_b  <= '0;
      alu_op1       <= '0;
      alu_op2       <= '0;
      alu_instr     <= '0;
      alu_instr_opt <= 1'b0;
      alu_e         <= 1'b0;
      psw_q         <= '0;
      rf_wr_en      <= 1'b0;
      rf_wr_addr    <= '0;
      rf_wr_data    <= '0;
      illegal       <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      dst_q         <= dst_d;
      src_q         <= src_d;
      rc_q          <= rc_d;
      const_q       <= const_d;
      upd_q         <= upd_d;
      dec_ready     <= dec_ready_d;
      busy          <= busy_d;
      rf_rd_addr_a  <= rd_addr_a_d;
      rf_rd_addr_b  <= rd_addr_b_d;
      alu_op1       <= op1_d;
      alu_op2       <= op2_d;
      alu_instr     <= alu_instr_d;
      alu_instr_opt <= alu_instr_opt_d;
      alu_e         <= alu_e_d;
      psw_q         <= psw_d;
      rf_wr_en      <= wr_en_d;
      rf_wr_addr    <= wr_addr_d;
      rf_wr_data    <= wr_data_d;
      illegal       <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural register file and ALU around the DUT,
// a table of single instructions plus reset-in-flight and back-to-back sequences.
module tb_alu_exec_ctrl;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dec_valid = 1'b0;
  logic          dec_ready;
  logic [4:0]    dec_instr = '0;
  logic [AW-1:0] dec_dst = '0;
  logic [AW-1:0] dec_src = '0;
  logic          dec_rc = 1'b0;
  logic [15:0]   dec_const = '0;
  logic          dec_psw_upd = 1'b0;
  logic [AW-1:0] rf_rd_addr_a, rf_rd_addr_b;
  logic [15:0]   rf_rd_data_a = '0;
  logic [15:0]   rf_rd_data_b = '0;
  logic [15:0]   alu_op1, alu_op2;
  logic [5:0]    alu_instr;
  logic          alu_instr_opt;
  logic          alu_e;
  logic [15:0]   alu_result;
  logic [15:0]   alu_psw = '0;
  logic [15:0]   psw_q;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [15:0]   rf_wr_data;
  logic          illegal;
  logic          busy;

  alu_exec_ctrl #(.RF_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_dst(dec_dst), .dec_src(dec_src), .dec_rc(dec_rc),
    .dec_const(dec_const), .dec_psw_upd(dec_psw_upd),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_instr(alu_instr),
    .alu_instr_opt(alu_instr_opt), .alu_e(alu_e),
    .alu_result(alu_result), .alu_psw(alu_psw), .psw_q(psw_q),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Register file: synchronous read, write on rising edge, bench preload port
  logic [15:0]   rf [8];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [15:0]   pre_data = '0;

  initial for (int i = 0; i < 8; i++) rf[i] = '0;

  always @(posedge clk) begin
    if (pre_en) rf[pre_addr] <= pre_data;
    if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    rf_rd_data_a <= rf[rf_rd_addr_a];
    rf_rd_data_b <= rf[rf_rd_addr_b];
  end

  // ALU stand-in: result valid only while enabled, PSW_o registered on the strobe
  function automatic logic [18:0] alu_model(input logic [5:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] r;
    case (op)
      6'h00, 6'h01: r = {1'b0, a} + {1'b0, b};
      6'h0A, 6'h0B: r = {1'b0, a} - {1'b0, b};
      6'h12, 6'h13: r = {1'b0, a & b};
      default:      r = {1'b0, a ^ b};
    endcase
    return {r[15], (r[15:0] == 16'h0), r[16], r[15:0]};
  endfunction

  logic [18:0] alu_m;
  always_comb alu_m = alu_model(alu_instr, alu_op1, alu_op2);
  assign alu_result = alu_e ? alu_m[15:0] : 16'hDEAD;

  always @(posedge clk)
    if (alu_e) alu_psw <= alu_instr_opt ? {13'b0, alu_m[18:16]} : psw_q;

  // Scoreboard of expected register-file writes
  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;
  wr_t sb_q[$];
  wr_t sb_e;

  always @(negedge clk) begin
    if (rf_wr_en) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb unexpected write: addr %0d data 0x%0h, expected no write", rf_wr_addr, rf_wr_data);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb wr_addr", 32'(rf_wr_addr), 32'(sb_e.addr));
        check("sb wr_data", 32'(rf_wr_data), 32'(sb_e.data));
      end
    end
    if (rf_wr_en || illegal) check("wr_en/illegal exclusive", 32'(rf_wr_en & illegal), 32'd0);
  end

  typedef struct {
    logic [4:0]    op;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic          rc;
    logic [15:0]   cval;
    logic          upd;
    logic [15:0]   a_init;
    logic [15:0]   b_init;
    logic          exp_wr;
    logic [15:0]   exp_data;
    logic [15:0]   exp_psw;
    logic          exp_ill;
  } vec_t;

  vec_t vecs[10];

  task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drive_fields(input logic [4:0] op, input logic [AW-1:0] dst,
                              input logic [AW-1:0] src, input logic rc,
                              input logic [15:0] cval, input logic upd);
    dec_instr = op; dec_dst = dst; dec_src = src;
    dec_rc = rc; dec_const = cval; dec_psw_upd = upd;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [3:0] ae, we, rd, bz, il;
    preload(v.dst, v.a_init);
    if (!v.rc && v.src != v.dst) preload(v.src, v.b_init);
    if (v.exp_wr) sb_q.push_back('{v.dst, v.exp_data});
    @(negedge clk);
    drive_fields(v.op, v.dst, v.src, v.rc, v.cval, v.upd);
    dec_valid = 1'b1;
    @(posedge clk); #1;
    dec_valid = 1'b0;
    check($sformatf("v%0d illegal at accept", i), 32'(illegal), 32'(v.exp_ill));
    check($sformatf("v%0d busy at accept", i), 32'(busy), 32'(!v.exp_ill));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      ae[k] = alu_e; we[k] = rf_wr_en; rd[k] = dec_ready; bz[k] = busy; il[k] = illegal;
    end
    check($sformatf("v%0d alu_e cycles", i), 32'(ae), v.exp_ill ? 32'h0 : 32'h2);
    check($sformatf("v%0d wr_en cycles", i), 32'(we), v.exp_wr ? 32'h4 : 32'h0);
    check($sformatf("v%0d ready cycles", i), 32'(rd), v.exp_ill ? 32'hF : 32'hC);
    check($sformatf("v%0d busy cycles", i), 32'(bz), v.exp_ill ? 32'h0 : 32'h7);
    check($sformatf("v%0d illegal after", i), 32'(il), 32'h0);
    check($sformatf("v%0d psw_q", i), 32'(psw_q), 32'(v.exp_psw));
    check($sformatf("v%0d rf[dst]", i), 32'(rf[v.dst]), v.exp_wr ? 32'(v.exp_data) : 32'(v.a_init));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc[2];
    int cyc, n_acc;
    logic rdy;

    //        op     dst   src   rc    cval      upd   a_init    b_init    wr    data      psw       ill
    vecs[0] = '{5'h00, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h0004, 1'b1, 16'h0007, 16'h0000, 1'b0};
    vecs[1] = '{5'h00, 3'd3, 3'd0, 1'b1, 16'h0001, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'h0003, 1'b0};
    vecs[2] = '{5'h0A, 3'd4, 3'd5, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 16'h0002, 1'b0};
    vecs[3] = '{5'h1F, 3'd6, 3'd7, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0002, 1'b1};
    vecs[4] = '{5'h04, 3'd6, 3'd7, 1'b0, 16'h0000, 1'b0, 16'h00F0, 16'h0FF0, 1'b1, 16'h0F00, 16'h0002, 1'b0};
    vecs[5] = '{5'h12, 3'd0, 3'd1, 1'b0, 16'h0000, 1'b1, 16'h8001, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{5'h0B, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h0005, 1'b0};
    vecs[7] = '{5'h01, 3'd5, 3'd0, 1'b1, 16'h8000, 1'b1, 16'h8000, 16'h0000, 1'b1, 16'h0000, 16'h0003, 1'b0};
    vecs[8] = '{5'h13, 3'd6, 3'd6, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0002, 1'b0};
    vecs[9] = '{5'h00, 3'd7, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h0001, 16'h0002, 1'b1, 16'h0003, 16'h0002, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset dec_ready", 32'(dec_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset psw_q", 32'(psw_q), 32'd0);
    check("reset alu_e", 32'(alu_e), 32'd0);
    check("reset rf_wr_en", 32'(rf_wr_en), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset alu_op1", 32'(alu_op1), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while the ALU strobe is high drops the instruction (psw_q is 2 here)
    preload(3'd3, 16'h1234);
    preload(3'd4, 16'h0001);
    @(negedge clk);
    drive_fields(5'h00, 3'd3, 3'd4, 1'b0, 16'h0000, 1'b1);
    dec_valid = 1'b1;
    @(posedge clk); #1;
    dec_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_strb alu_e before reset", 32'(alu_e), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_strb rf_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_strb dec_ready", 32'(dec_ready), 32'd1);
    check("rst_strb busy", 32'(busy), 32'd0);
    check("rst_strb psw_q", 32'(psw_q), 32'd0);
    check("rst_strb alu_e", 32'(alu_e), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_strb rf[3] kept", 32'(rf[3]), 32'h1234);
    check("rst_strb still idle", 32'(busy), 32'd0);

    // Back-to-back adds; the second reads the first's destination
    preload(3'd1, 16'h0003);
    preload(3'd2, 16'h0004);
    sb_q.push_back('{3'd1, 16'h0007});
    sb_q.push_back('{3'd2, 16'h000B});
    @(negedge clk);
    drive_fields(5'h00, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b1);
    dec_valid = 1'b1;
    cyc = 0;
    n_acc = 0;
    acc[0] = 0;
    acc[1] = 0;
    while (n_acc < 2 && cyc < 20) begin
      rdy = dec_ready;
      @(posedge clk);
      cyc++;
      if (rdy) begin
        acc[n_acc] = cyc;
        n_acc++;
        #1;
        if (n_acc == 1) drive_fields(5'h00, 3'd2, 3'd1, 1'b0, 16'h0000, 1'b1);
        else dec_valid = 1'b0;
      end
      @(negedge clk);
    end
    dec_valid = 1'b0;
    check("b2b accepts seen", 32'(n_acc), 32'd2);
    check("b2b accept spacing", 32'(acc[1] - acc[0]), 32'd4);
    repeat (4) @(posedge clk);
    #1;
    check("b2b rf[1]", 32'(rf[1]), 32'h0007);
    check("b2b rf[2]", 32'(rf[2]), 32'h000B);
    check("b2b psw_q", 32'(psw_q), 32'h0000);
    check("b2b idle", 32'(busy), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
